wb_port_scheduler: RTL
======================

Name: wb_port_scheduler

Overview:
- Shares the register file's single write port between two requesters:
  - the in-order pipeline writeback (priority source);
  - a multi-cycle unit (MDU: mul/div) returning results out of order with the pipeline.
- Holds one blocked MDU result in a buffer and forces a one-cycle pipeline stall to prevent starvation.
- Keeps a 32-entry busy scoreboard that decode uses for RAW/WAW hazard stalls.
- Sits between the writeback stage, the MDU and the register file. The register file's own stall input is tied low when this block drives its write port.

Parameters:
- XLEN, 32, data width.
- STARVE_LIMIT, 4, consecutive blocked cycles of a buffered MDU result before a forced pipeline stall (range 1..15).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- wb_valid_i  in  1  pipeline writeback request
- wb_addr_i  in  5  pipeline destination register
- wb_data_i  in  XLEN  pipeline result
- mdu_issue_i  in  1  MDU op issued from decode this cycle
- mdu_issue_addr_i  in  5  destination of issued MDU op
- mdu_issue_ready_o  out  1  issue allowed: destination not busy
- mdu_valid_i  in  1  MDU result valid
- mdu_addr_i  in  5  MDU result destination
- mdu_data_i  in  XLEN  MDU result
- mdu_ready_o  out  1  MDU result accepted when high with mdu_valid_i
- rs1_addr_i  in  5  decode source 1
- rs2_addr_i  in  5  decode source 2
- rd_addr_i  in  5  decode destination
- hazard_o  out  1  decode must stall: rs1, rs2 or rd busy
- pipe_stall_o  out  1  forced pipeline stall (starvation relief)
- rf_we_o  out  1  register file write enable
- rf_addr_o  out  5  register file write address
- rf_data_o  out  XLEN  register file write data
- err_o  out  1  sticky protocol error

Behaviour:
- Reset, sampled on the rising edge while rst_i=1:
  - busy[31:0]=0, buffer empty, starvation counter=0, state=IDLE.
  - pipe_stall_o=0, err_o=0, rf_we_o=0.
  - mdu_ready_o=1, mdu_issue_ready_o=1, hazard_o=0.
  - Reset mid-operation discards a buffered result and all busy bits.
- Register x0:
  - Never marked busy; always reads not-busy.
  - Writes to x0 never assert rf_we_o; an MDU result to x0 is accepted and dropped.
- Scoreboard:
  - mdu_issue_i & mdu_issue_ready_o sets busy[mdu_issue_addr_i] at the next edge.
  - The bit clears on the edge at which the MDU result for that address is written, or dropped for x0.
  - mdu_issue_ready_o = !busy[mdu_issue_addr_i]. There is no same-cycle clear bypass, so set and clear of the same address never coincide.
  - hazard_o = busy[rs1] | busy[rs2] | busy[rd], evaluated combinationally.
- Write-port arbitration is combinational, evaluated each cycle in this order:
  1. State FORCE: write the buffer; the pipeline write is not performed (the pipeline holds it under pipe_stall_o).
  2. wb_valid_i: write the pipeline result.
  3. Buffer full: write the buffer.
  4. mdu_valid_i with buffer empty: write the MDU result directly (zero latency).
- MDU acceptance:
  - mdu_ready_o = buffer empty.
  - An accepted MDU result that is not written that cycle (pipeline wins) is captured in the buffer.
  - The buffer is freed on the edge its entry is written; mdu_ready_o rises the following cycle.
- State machine:
  - IDLE: buffer empty. Go to HELD when an accepted MDU result is buffered.
  - HELD: buffer full.
    - Each cycle in which the buffer is blocked by wb_valid_i increments the counter; a cycle that writes the buffer returns to IDLE and clears the counter.
    - When the counter reaches STARVE_LIMIT, go to FORCE.
  - FORCE: pipe_stall_o=1 (registered, exactly one cycle). The buffer is written; go to IDLE with counter=0.
- Error conditions set err_o (sticky until reset):
  - pipeline write to a busy register;
  - mdu_valid_i for an address that is not busy (x0 excepted);
  - mdu_issue_i while mdu_issue_ready_o=0.
- Widths: addresses 5 bits; counter 4 bits, saturating, never wraps.

Decomposition:
- Shared package holds:
  - XLEN;
  - REG_ADDR_W=5;
  - state encoding IDLE/HELD/FORCE;
  - source-select enum SRC_NONE/SRC_WB/SRC_MDU/SRC_BUF.
- Natural sub-module: wb_scoreboard (busy vector, set/clear, three-port hazard lookup, issue-ready).

Test Plan:
- MDU only: issue x5; next cycle mdu_valid with addr 5, data 0xDEADBEEF → same cycle rf_we_o=1, rf_addr_o=5, rf_data_o=0xDEADBEEF; busy[5] cleared next cycle; hazard_o for rs1=5 drops.
- Conflict: wb_valid (x3, 0x11) and mdu_valid (x7, 0x22) in the same cycle → x3 written; buffer captures x7; mdu_ready_o=0 next cycle; x7 written on the first cycle without wb_valid.
- Starvation: buffered x7 while wb_valid is held high continuously with STARVE_LIMIT=4 → after 4 blocked cycles pipe_stall_o=1 for exactly 1 cycle; x7 written in that cycle; pending pipeline write performed the cycle after.
- Hazard/issue: issue x9, then decode presents rs2=9 → hazard_o=1; mdu_issue_ready_o=0 for addr 9; both clear after the x9 result is written.
- x0 and errors: MDU result to x0 → rf_we_o=0, accepted. wb_valid to busy x9 → err_o=1 and stays 1 until rst_i.
- Reset mid-operation: buffer full and busy[4]=1, assert rst_i for one cycle → mdu_ready_o=1, hazard_o=0, pipe_stall_o=0, no write of the buffered data.

Source files
------------

// File: rtl/wb_port_scheduler_pkg.sv
// Shared types and widths for the register-file write-port scheduler.
// Imported by the scheduler top and its scoreboard.
package wb_port_scheduler_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        FORCE
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_WB,
        SRC_MDU,
        SRC_BUF
    } src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy-bit scoreboard for MDU destinations.
// Provides decode hazard, issue-ready and busy lookups for error checks.
module wb_scoreboard
    import wb_port_scheduler_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  set_i,
    input  logic [REG_ADDR_W-1:0] set_addr_i,
    input  logic                  clr_i,
    input  logic [REG_ADDR_W-1:0] clr_addr_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic [REG_ADDR_W-1:0] issue_addr_i,
    input  logic [REG_ADDR_W-1:0] wb_addr_i,
    input  logic [REG_ADDR_W-1:0] mdu_addr_i,
    output logic                  hazard_o,
    output logic                  issue_ready_o,
    output logic                  wb_busy_o,
    output logic                  mdu_busy_o
);

    logic [31:0] r_busy;
    logic [31:0] w_busy_next;

    // Set after clear; bit 0 is forced low so x0 can never stall decode.
    always_comb begin
        w_busy_next = r_busy;
        if (clr_i) w_busy_next[clr_addr_i] = 1'b0;
        if (set_i) w_busy_next[set_addr_i] = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_busy <= '0;
        else       r_busy <= w_busy_next;
    end

    assign hazard_o      = r_busy[rs1_addr_i] | r_busy[rs2_addr_i]
                         | r_busy[rd_addr_i];
    assign issue_ready_o = ~r_busy[issue_addr_i];
    assign wb_busy_o     = r_busy[wb_addr_i];
    assign mdu_busy_o    = r_busy[mdu_addr_i];

endmodule

// File: rtl/wb_port_scheduler.sv
// Arbitrates the single register-file write port between pipeline
// writeback and out-of-order MDU results, with a one-entry MDU buffer.
module wb_port_scheduler
    import wb_port_scheduler_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            wb_valid_i,
    input  logic [4:0]      wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            mdu_issue_i,
    input  logic [4:0]      mdu_issue_addr_i,
    output logic            mdu_issue_ready_o,
    input  logic            mdu_valid_i,
    input  logic [4:0]      mdu_addr_i,
    input  logic [XLEN-1:0] mdu_data_i,
    output logic            mdu_ready_o,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    input  logic [4:0]      rd_addr_i,
    output logic            hazard_o,
    output logic            pipe_stall_o,
    output logic            rf_we_o,
    output logic [4:0]      rf_addr_o,
    output logic [XLEN-1:0] rf_data_o,
    output logic            err_o
);

    state_e          r_state;
    state_e          w_state_n;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_n;
    logic [3:0]      w_cnt_inc;
    logic            r_buf_valid;
    logic [4:0]      r_buf_addr;
    logic [XLEN-1:0] r_buf_data;
    logic            r_stall;
    logic            r_err;

    src_e            w_src;
    logic            w_mdu_acc;
    logic            w_mdu_nz;
    logic            w_capture;
    logic            w_set;
    logic            w_clr;
    logic [4:0]      w_clr_addr;
    logic            w_wb_busy;
    logic            w_mdu_busy;
    logic            w_err;

    assign w_mdu_acc = mdu_valid_i & ~r_buf_valid;
    assign w_mdu_nz  = (mdu_addr_i != 5'd0);

    always_comb begin
        w_src = SRC_NONE;
        if (r_state == FORCE)  w_src = SRC_BUF;
        else if (wb_valid_i)   w_src = SRC_WB;
        else if (r_buf_valid)  w_src = SRC_BUF;
        else if (w_mdu_acc)    w_src = SRC_MDU;
    end

    always_comb begin
        rf_addr_o = 5'd0;
        rf_data_o = '0;
        case (w_src)
            SRC_WB: begin
                rf_addr_o = wb_addr_i;
                rf_data_o = wb_data_i;
            end
            SRC_MDU: begin
                rf_addr_o = mdu_addr_i;
                rf_data_o = mdu_data_i;
            end
            SRC_BUF: begin
                rf_addr_o = r_buf_addr;
                rf_data_o = r_buf_data;
            end
            default: ;
        endcase
    end

    // Gated by reset so a discarded buffer entry never reaches the RF.
    assign rf_we_o = (w_src != SRC_NONE) & (rf_addr_o != 5'd0) & ~rst_i;

    // x0 results are accepted and dropped, never buffered.
    assign w_capture  = w_mdu_acc & w_mdu_nz & (w_src != SRC_MDU);
    assign w_set      = mdu_issue_i & mdu_issue_ready_o
                      & (mdu_issue_addr_i != 5'd0);
    assign w_clr      = (w_src == SRC_BUF)
                      | ((w_src == SRC_MDU) & w_mdu_nz);
    assign w_clr_addr = (w_src == SRC_BUF) ? r_buf_addr : mdu_addr_i;

    wb_scoreboard u_sb (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .set_i        (w_set),
        .set_addr_i   (mdu_issue_addr_i),
        .clr_i        (w_clr),
        .clr_addr_i   (w_clr_addr),
        .rs1_addr_i   (rs1_addr_i),
        .rs2_addr_i   (rs2_addr_i),
        .rd_addr_i    (rd_addr_i),
        .issue_addr_i (mdu_issue_addr_i),
        .wb_addr_i    (wb_addr_i),
        .mdu_addr_i   (mdu_addr_i),
        .hazard_o     (hazard_o),
        .issue_ready_o(mdu_issue_ready_o),
        .wb_busy_o    (w_wb_busy),
        .mdu_busy_o   (w_mdu_busy)
    );

    assign w_cnt_inc = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_capture) w_state_n = HELD;
            end
            HELD: begin
                if (w_src == SRC_BUF) begin
                    w_state_n = IDLE;
                    w_cnt_n   = 4'd0;
                end else begin
                    w_cnt_n = w_cnt_inc;
                    if (w_cnt_inc >= 4'(STARVE_LIMIT)) w_state_n = FORCE;
                end
            end
            FORCE: begin
                w_state_n = IDLE;
                w_cnt_n   = 4'd0;
            end
            default: begin
                w_state_n = IDLE;
                w_cnt_n   = 4'd0;
            end
        endcase
    end

    assign w_err = (wb_valid_i & w_wb_busy)
                 | (mdu_valid_i & w_mdu_nz & ~w_mdu_busy)
                 | (mdu_issue_i & ~mdu_issue_ready_o);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_buf_valid <= 1'b0;
            r_buf_addr  <= 5'd0;
            r_buf_data  <= '0;
            r_stall     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_stall <= (w_state_n == FORCE);
            r_err   <= r_err | w_err;
            if (w_capture) begin
                r_buf_valid <= 1'b1;
                r_buf_addr  <= mdu_addr_i;
                r_buf_data  <= mdu_data_i;
            end else if (w_src == SRC_BUF) begin
                r_buf_valid <= 1'b0;
            end
        end
    end

    assign mdu_ready_o  = ~r_buf_valid;
    assign pipe_stall_o = r_stall;
    assign err_o        = r_err;

endmodule
